coin_credit_acc: RTL and testbench
==================================

Name: coin_credit_acc

Overview:
- Payment stage directly upstream of the ticket dispenser. Accepts coin events and accumulates credit toward a fixed ticket price.
- When credit reaches the price, issues a one-cycle ready pulse (out_RDY9) that drives the dispenser's in_RDY9.
- Waits for the dispenser's completion flag (state_cmp9), then releases change and returns to idle.
- Also handles customer cancel/refund and rejects coins while a ticket is in flight.

Parameters:
- PRICE, 9, ticket price in credit units.
- CREDIT_W, 5, width of the credit and change registers. Must hold PRICE+4, the maximum reachable credit.
- TIMEOUT, 64, idle cycles in COLLECT before automatic refund. Used only with COIN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- coin_valid  in  1  one-cycle strobe: a coin was inserted.
- coin_type  in  2  coin value: 00=1, 01=2, 10=5, 11=invalid.
- cancel  in  1  customer cancel request, level sampled each clk.
- state_cmp9  in  1  dispenser reports ticket issued.
- out_RDY9  out  1  one-cycle pulse: price reached; goes to dispenser in_RDY9.
- credit  out  CREDIT_W  current accumulated credit.
- coin_reject  out  1  one-cycle pulse: the coin sampled last cycle was returned.
- change_valid  out  1  one-cycle pulse: change_amt is valid for the coin return.
- change_amt  out  CREDIT_W  amount to return (change or refund).
- busy  out  1  high in READY and WAIT_CMP.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - credit, change_amt, out_RDY9, coin_reject, change_valid and busy all 0.
  - Reset overrides all other inputs, including mid-transaction; accumulated credit is discarded and no refund is issued.
- All outputs are registered. An input sampled at edge n produces its effect visible after edge n.
- Coin acceptance (IDLE and COLLECT only):
  - A valid coin_type adds 1/2/5 to credit.
  - coin_type=11 is not added; coin_reject pulses.
- IDLE:
  - Valid coin -> credit=value, go to COLLECT. If value>=PRICE, go directly to READY instead.
  - cancel with credit 0 -> no action.
- COLLECT:
  - Valid coin -> credit+=value. If the new credit >= PRICE, go to READY and latch change_amt = new credit - PRICE.
  - cancel=1 -> change_amt=credit, change_valid pulses, credit=0, go to IDLE.
  - cancel and coin_valid in the same cycle: cancel wins, the coin is rejected (coin_reject pulses), and the refund excludes that coin.
- READY (exactly 1 cycle):
  - out_RDY9=1 and busy=1; unconditionally go to WAIT_CMP.
- WAIT_CMP:
  - busy=1; credit holds.
  - Any coin_valid -> coin_reject pulse, credit unchanged.
  - cancel is ignored.
  - state_cmp9=1 -> credit=0. If change_amt!=0, change_valid pulses. Go to IDLE.
  - No timeout; waits indefinitely.
- state_cmp9 arriving outside WAIT_CMP is ignored.
- Arithmetic is unsigned. Credit never exceeds PRICE+4 (largest credit before the price, PRICE-1, plus the 5-unit coin), so no overflow or wrap is possible.
- change_amt holds its value until the next latch or reset.
- A new transaction can accept a coin in the cycle immediately after returning to IDLE.

Optional Feature:
- Macro: COIN_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT and clears on each coin_valid.
  - When it reaches TIMEOUT-1 with no coin, the block performs an auto-refund identical to cancel and returns to IDLE.
  - A coin arriving on the terminal cycle is accepted and the timeout does not fire.
- Not defined:
  - No counter logic; COLLECT waits indefinitely.

Decomposition:
- Shared package (coin_pkg) holds:
  - state enum IDLE/COLLECT/READY/WAIT_CMP;
  - coin_type encodings and a value-lookup function;
  - default PRICE and CREDIT_W.
- One natural sub-module: coin_decode, a combinational coin_type -> value/invalid decoder, reused by the dispenser's bench.
- The FSM, accumulator and timeout counter stay in coin_credit_acc.

Test Plan:
- Reset: rst=0 for 2 clks with coin_valid=1 -> credit=0, all pulses 0, state IDLE.
- Exact payment:
  - Stimulus: coins 5, 2, 2 on consecutive clks.
  - Required: credit 5,7,9; out_RDY9 high exactly 1 cycle after credit=9; busy=1.
  - Then state_cmp9=1 -> credit=0, no change_valid.
- Overpay:
  - Stimulus: coins 5, 5.
  - Required: change_amt=1, out_RDY9 pulse.
  - Also: a coin (type 00) during WAIT_CMP -> coin_reject pulse, credit stays 10.
  - Then state_cmp9 -> change_valid pulse with change_amt=1.
- Cancel:
  - Stimulus: coins 2, 1, then cancel with coin_valid type 10 in the same cycle.
  - Required: change_valid with change_amt=3, coin_reject pulse, credit=0, IDLE.
- Invalid and stray inputs:
  - coin_type=11 in COLLECT -> coin_reject pulse, credit unchanged.
  - state_cmp9 pulsed in IDLE -> no effect.
- COIN_TIMEOUT_EN, TIMEOUT=8:
  - Insert coin 2, then idle 8 cycles -> refund change_amt=2.
  - Repeat with a coin on cycle 7 -> no refund, credit=3.

Source files
------------

// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_pkg
// Description : Shared types and constants for the coin payment stage:
//               FSM state encoding, coin_type encodings, coin value lookup
//               and default price / credit width.
// Revision    : 1.0 - initial release
// ============================================================================
package coin_pkg;

    // Default configuration
    localparam int c_PRICE_DEF    = 9;
    localparam int c_CREDIT_W_DEF = 5;

    // Payment FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_READY    = 2'd2,
        ST_WAIT_CMP = 2'd3
    } state_t;

    // coin_type encodings
    localparam logic [1:0] c_COIN_ONE  = 2'b00;
    localparam logic [1:0] c_COIN_TWO  = 2'b01;
    localparam logic [1:0] c_COIN_FIVE = 2'b10;
    localparam logic [1:0] c_COIN_INV  = 2'b11;

    // Credit value of a coin; the invalid encoding is worth nothing
    function automatic logic [2:0] coin_value(input logic [1:0] coin_type);
        logic [2:0] v;
        case (coin_type)
            c_COIN_ONE:  v = 3'd1;
            c_COIN_TWO:  v = 3'd2;
            c_COIN_FIVE: v = 3'd5;
            default:     v = 3'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_credit_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_credit_acc_if
// Description : Coin acceptor / dispenser handshake bundle. The slave modport
//               is the payment stage, the master modport is whoever drives
//               coins and the dispenser completion flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_credit_acc_if
    import coin_pkg::*;
#(
    parameter int CREDIT_W = c_CREDIT_W_DEF
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                cancel;
    logic                state_cmp9;
    logic                out_RDY9;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                busy;

    modport slave (
        input  coin_valid,
        input  coin_type,
        input  cancel,
        input  state_cmp9,
        output out_RDY9,
        output credit,
        output coin_reject,
        output change_valid,
        output change_amt,
        output busy
    );

    modport master (
        output coin_valid,
        output coin_type,
        output cancel,
        output state_cmp9,
        input  out_RDY9,
        input  credit,
        input  coin_reject,
        input  change_valid,
        input  change_amt,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/coin_decode.sv
`default_nettype none
// ============================================================================
// Module      : coin_decode
// Description : Combinational coin_type decoder: credit value of the coin and
//               an invalid flag for the unused encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_decode
    import coin_pkg::*;
(
    input  wire logic [1:0] i_coin_type,
    output logic      [2:0] o_value,
    output logic            o_invalid
);

    // Pure lookup; no state
    always_comb begin
        o_value   = coin_value(i_coin_type);
        o_invalid = (i_coin_type == c_COIN_INV);
    end

endmodule
`default_nettype wire

// File: rtl/coin_credit_acc.sv
`default_nettype none
// ============================================================================
// Module      : coin_credit_acc
// Description : Coin credit accumulator. Collects coins toward PRICE, pulses
//               out_RDY9 to the ticket dispenser, waits for state_cmp9, then
//               returns change. Handles cancel/refund and rejects coins while
//               a ticket is in flight. All outputs are registered.
//               Optional macro COIN_TIMEOUT_EN: auto-refund after TIMEOUT
//               coin-less cycles in COLLECT.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_credit_acc
    import coin_pkg::*;
#(
    parameter int PRICE    = c_PRICE_DEF,
    parameter int CREDIT_W = c_CREDIT_W_DEF,
    parameter int TIMEOUT  = 64
)(
    input  wire logic         clk,
    input  wire logic         rst,
    coin_credit_acc_if.slave  bus
);

    localparam logic [CREDIT_W-1:0] c_PRICE = CREDIT_W'(PRICE);

    state_t              r_state;
    state_t              w_nxt_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_nxt_credit;
    logic [CREDIT_W-1:0] r_change;
    logic [CREDIT_W-1:0] w_nxt_change;
    logic                r_rdy;
    logic                w_nxt_rdy;
    logic                r_reject;
    logic                w_nxt_reject;
    logic                r_change_valid;
    logic                w_nxt_change_valid;
    logic                r_busy;
    logic                w_nxt_busy;

    logic [2:0]          w_coin_val;
    logic                w_coin_inv;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_timeout;

    coin_decode u_decode (
        .i_coin_type (bus.coin_type),
        .o_value     (w_coin_val),
        .o_invalid   (w_coin_inv)
    );

    // Credit after accepting the current coin (credit is 0 in IDLE)
    assign w_sum = r_credit + CREDIT_W'(w_coin_val);

`ifdef COIN_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_idle_cnt;
    logic [c_CNT_W-1:0] w_nxt_idle_cnt;

    // A coin on the terminal cycle wins over the timeout
    assign w_timeout = (r_idle_cnt == c_TMO_LAST) && !bus.coin_valid;

    // Idle counter advances only while staying in COLLECT without a coin
    always_comb begin
        w_nxt_idle_cnt = '0;
        if (r_state == ST_COLLECT && w_nxt_state == ST_COLLECT && !bus.coin_valid)
            w_nxt_idle_cnt = r_idle_cnt + 1'b1;
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (!rst)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= w_nxt_idle_cnt;
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Next state, next credit/change and next output pulses
    always_comb begin
        w_nxt_state        = r_state;
        w_nxt_credit       = r_credit;
        w_nxt_change       = r_change;
        w_nxt_reject       = 1'b0;
        w_nxt_change_valid = 1'b0;

        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (r_state == ST_COLLECT && (bus.cancel || w_timeout)) begin
                    // Refund everything collected; a coin arriving now is returned
                    w_nxt_change       = r_credit;
                    w_nxt_change_valid = 1'b1;
                    w_nxt_credit       = '0;
                    w_nxt_reject       = bus.coin_valid;
                    w_nxt_state        = ST_IDLE;
                end else if (bus.coin_valid) begin
                    if (w_coin_inv) begin
                        w_nxt_reject = 1'b1;
                    end else if (w_sum >= c_PRICE) begin
                        w_nxt_credit = w_sum;
                        w_nxt_change = w_sum - c_PRICE;
                        w_nxt_state  = ST_READY;
                    end else begin
                        w_nxt_credit = w_sum;
                        w_nxt_state  = ST_COLLECT;
                    end
                end
            end
            ST_READY: begin
                w_nxt_reject = bus.coin_valid;
                w_nxt_state  = ST_WAIT_CMP;
            end
            ST_WAIT_CMP: begin
                w_nxt_reject = bus.coin_valid;
                if (bus.state_cmp9) begin
                    w_nxt_credit       = '0;
                    w_nxt_change_valid = (r_change != '0);
                    w_nxt_state        = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        w_nxt_rdy  = (w_nxt_state == ST_READY);
        w_nxt_busy = (w_nxt_state == ST_READY) || (w_nxt_state == ST_WAIT_CMP);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_change       <= '0;
            r_rdy          <= 1'b0;
            r_reject       <= 1'b0;
            r_change_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_credit       <= w_nxt_credit;
            r_change       <= w_nxt_change;
            r_rdy          <= w_nxt_rdy;
            r_reject       <= w_nxt_reject;
            r_change_valid <= w_nxt_change_valid;
            r_busy         <= w_nxt_busy;
        end
    end

    assign bus.out_RDY9     = r_rdy;
    assign bus.credit       = r_credit;
    assign bus.coin_reject  = r_reject;
    assign bus.change_valid = r_change_valid;
    assign bus.change_amt   = r_change;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_credit_acc
// Description : Self-checking bench for coin_credit_acc. Vector table of
//               {inputs, expected registered outputs}; expected records are
//               queued at drive time and popped after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_credit_acc;
    import coin_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    coin_credit_acc_if #(.CREDIT_W(5)) bus ();

    coin_credit_acc #(
        .PRICE    (9),
        .CREDIT_W (5),
        .TIMEOUT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       rst_n;
        logic       cv;
        logic [1:0] ct;
        logic       can;
        logic       cmp;
        logic [4:0] e_credit;
        logic       e_rdy;
        logic       e_rej;
        logic       e_chv;
        logic [4:0] e_chg;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_no = 0;

    function automatic vec_t mk(input logic rst_n, input logic cv, input logic [1:0] ct,
                                input logic can, input logic cmp, input logic [4:0] cr,
                                input logic rdy, input logic rej, input logic chv,
                                input logic [4:0] chg, input logic busy);
        vec_t v;
        v.rst_n = rst_n; v.cv = cv; v.ct = ct; v.can = can; v.cmp = cmp;
        v.e_credit = cr; v.e_rdy = rdy; v.e_rej = rej; v.e_chv = chv;
        v.e_chg = chg; v.e_busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare against the registered outputs
    task automatic compare_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard vec%0d: got empty queue expected entry", vec_no);
            return;
        end
        e = exp_q.pop_front();
        chk("credit",       vec_no, bus.credit,                e.e_credit);
        chk("out_RDY9",     vec_no, {4'd0, bus.out_RDY9},      {4'd0, e.e_rdy});
        chk("coin_reject",  vec_no, {4'd0, bus.coin_reject},   {4'd0, e.e_rej});
        chk("change_valid", vec_no, {4'd0, bus.change_valid},  {4'd0, e.e_chv});
        chk("change_amt",   vec_no, bus.change_amt,            e.e_chg);
        chk("busy",         vec_no, {4'd0, bus.busy},          {4'd0, e.e_busy});
    endtask

    // Drive one vector at the falling edge, check #1 after the next rising edge
    task automatic step(input vec_t v);
        rst            = v.rst_n;
        bus.coin_valid = v.cv;
        bus.coin_type  = v.ct;
        bus.cancel     = v.can;
        bus.state_cmp9 = v.cmp;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare_out();
        vec_no++;
        @(negedge clk);
    endtask

    // Idle cycle helper: no inputs, expected outputs given
    task automatic idle(input logic [4:0] cr, input logic [4:0] chg);
        step(mk(1, 0, 2'b00, 0, 0, cr, 0, 0, 0, chg, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_type  = 2'b00;
        bus.cancel     = 1'b0;
        bus.state_cmp9 = 1'b0;
        @(negedge clk);

        //             rst cv ct     can cmp | credit rdy rej chv chg busy
        // Reset with a coin present
        tbl.push_back(mk(0, 1, 2'b10, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 0, 0,   0, 0, 0, 0, 0, 0));
        // Exact payment 5,2,2
        tbl.push_back(mk(1, 1, 2'b10, 0, 0,   5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2'b01, 0, 0,   7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2'b01, 0, 0,   9, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0,   9, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0));
        // Overpay 5,5; coins rejected in READY and WAIT_CMP; cancel ignored
        tbl.push_back(mk(1, 1, 2'b10, 0, 0,   5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2'b10, 0, 0,  10, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 2'b00, 0, 0,  10, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 2'b00, 0, 0,  10, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 2'b00, 1, 0,  10, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1,   0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 1, 0));
        // Cancel with simultaneous coin: refund 3, coin returned
        tbl.push_back(mk(1, 1, 2'b01, 0, 0,   2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 2'b00, 0, 0,   3, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 2'b10, 1, 0,   0, 0, 1, 1, 3, 0));
        // Invalid coin in COLLECT, then cancel
        tbl.push_back(mk(1, 1, 2'b01, 0, 0,   2, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 1, 2'b11, 0, 0,   2, 0, 1, 0, 3, 0));
        tbl.push_back(mk(1, 0, 2'b00, 1, 0,   0, 0, 0, 1, 2, 0));
        // Stray state_cmp9 in IDLE and COLLECT; coin right after returning to IDLE
        tbl.push_back(mk(1, 0, 2'b00, 0, 1,   0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 2'b00, 0, 0,   1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1,   1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 2'b00, 1, 0,   0, 0, 0, 1, 1, 0));
        // Reset mid-transaction discards credit, no refund
        tbl.push_back(mk(1, 1, 2'b10, 0, 0,   5, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'b00, 1, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0));
        // Invalid coin in IDLE
        tbl.push_back(mk(1, 1, 2'b11, 0, 0,   0, 0, 1, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

`ifdef COIN_TIMEOUT_EN
        // Auto-refund after 8 coin-less cycles in COLLECT
        step(mk(1, 1, 2'b01, 0, 0, 2, 0, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) idle(5'd2, 5'd0);
        step(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2, 0));
        // Coin on the terminal cycle is accepted and suppresses the timeout
        step(mk(1, 1, 2'b01, 0, 0, 2, 0, 0, 0, 2, 0));
        for (int k = 0; k < 7; k++) idle(5'd2, 5'd2);
        step(mk(1, 1, 2'b00, 0, 0, 3, 0, 0, 0, 2, 0));
        step(mk(1, 0, 2'b00, 0, 0, 3, 0, 0, 0, 2, 0));
        step(mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 1, 3, 0));
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
